// File: rtl/pc_sequencer.sv
// Program-counter sequencer: sequential/branch/jump/call/return next-PC selection
// backed by a circular return-address stack with saturating count and sticky error flag.
module pc_sequencer #(
    parameter int ADDR_W    = 32,
    parameter int OFF_W     = 8,
    parameter int RAS_DEPTH = 4
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              STALL,
    input  logic              BRANCH,
    input  logic [1:0]        BR_MODE,
    input  logic              ZERO,
    input  logic              NEG,
    input  logic              JUMP,
    input  logic              CALL,
    input  logic              RET,
    input  logic [OFF_W-1:0]  OFFSET,
    output logic [ADDR_W-1:0] PC,
    output logic [ADDR_W-1:0] NEXTPC,
    output logic              RAS_EMPTY,
    output logic              RAS_FULL,
    output logic              RAS_ERR
);

    localparam int SP_W  = $clog2(RAS_DEPTH);
    localparam int CNT_W = SP_W + 1;

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_stack [RAS_DEPTH];
    logic [SP_W-1:0]   r_sp;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_err;

    logic [ADDR_W-1:0] w_seq;
    logic [ADDR_W-1:0] w_off_ext;
    logic [ADDR_W-1:0] w_tgt;
    logic [ADDR_W-1:0] w_top;
    logic [SP_W-1:0]   w_sp_dec;
    logic              w_cond;
    logic              w_taken;
    logic              w_empty;
    logic              w_full;
    logic              w_push;
    logic              w_pop;
    logic              w_under;
    logic              w_adv;

    assign w_seq     = r_pc + ADDR_W'(4);
    assign w_off_ext = ADDR_W'($signed(OFFSET));
    assign w_tgt     = w_seq + (w_off_ext << 2);

    always_comb begin
        w_cond = 1'b0;
        unique case (BR_MODE)
            2'b00: w_cond = ZERO;
            2'b01: w_cond = ~ZERO;
            2'b10: w_cond = NEG;
            2'b11: w_cond = ~NEG;
            default: w_cond = 1'b0;
        endcase
    end

    assign w_taken  = BRANCH & w_cond;
    assign w_empty  = (r_cnt == '0);
    assign w_full   = (r_cnt == CNT_W'(RAS_DEPTH));
    // sp addresses the next free slot; when full it also addresses the oldest entry
    assign w_sp_dec = r_sp - SP_W'(1);
    assign w_top    = r_stack[w_sp_dec];

    assign w_pop    = RET & ~w_empty;
    assign w_under  = RET & w_empty;
    assign w_push   = CALL & ~RET;
    assign w_adv    = ~RESET & ~STALL;

    always_comb begin
        NEXTPC = w_seq;
        if (w_pop) begin
            NEXTPC = w_top;
        end else if (RET) begin
            NEXTPC = w_seq;
        end else if (CALL || JUMP || w_taken) begin
            NEXTPC = w_tgt;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_pc  <= '0;
            r_sp  <= '0;
            r_cnt <= '0;
            r_err <= 1'b0;
        end else if (!STALL) begin
            r_pc <= NEXTPC;
            if (w_push) begin
                r_sp <= r_sp + SP_W'(1);
                if (w_full) begin
                    r_err <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end else if (w_pop) begin
                r_sp  <= w_sp_dec;
                r_cnt <= r_cnt - CNT_W'(1);
            end else if (w_under) begin
                r_err <= 1'b1;
            end
        end
    end

    // Entry contents are never cleared; the count gates every read after reset.
    always_ff @(posedge CLK) begin
        if (w_adv && w_push) begin
            r_stack[r_sp] <= w_seq;
        end
    end

    assign PC        = r_pc;
    assign RAS_EMPTY = w_empty;
    assign RAS_FULL  = w_full;
    assign RAS_ERR   = r_err;

endmodule

// File: tb/tb_pc_sequencer.sv
// Table-driven bench for pc_sequencer: each row is one clock of stimulus with the
// expected combinational NEXTPC and the registered state after the edge.
module tb_pc_sequencer;

    logic        CLK;
    logic        RESET;
    logic        STALL;
    logic        BRANCH;
    logic [1:0]  BR_MODE;
    logic        ZERO;
    logic        NEG;
    logic        JUMP;
    logic        CALL;
    logic        RET;
    logic [7:0]  OFFSET;
    logic [31:0] PC;
    logic [31:0] NEXTPC;
    logic        RAS_EMPTY;
    logic        RAS_FULL;
    logic        RAS_ERR;

    int n_checks = 0;
    int n_errors = 0;

    pc_sequencer #(
        .ADDR_W   (32),
        .OFF_W    (8),
        .RAS_DEPTH(4)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .STALL    (STALL),
        .BRANCH   (BRANCH),
        .BR_MODE  (BR_MODE),
        .ZERO     (ZERO),
        .NEG      (NEG),
        .JUMP     (JUMP),
        .CALL     (CALL),
        .RET      (RET),
        .OFFSET   (OFFSET),
        .PC       (PC),
        .NEXTPC   (NEXTPC),
        .RAS_EMPTY(RAS_EMPTY),
        .RAS_FULL (RAS_FULL),
        .RAS_ERR  (RAS_ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        br;
        logic [1:0]  mode;
        logic        z;
        logic        n;
        logic        j;
        logic        c;
        logic        r;
        logic [7:0]  off;
        logic [31:0] nxt;
        logic [31:0] pc;
        logic        e;
        logic        f;
        logic        err;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input string tag, input vec_t v);
        RESET   = v.rst;
        STALL   = v.stall;
        BRANCH  = v.br;
        BR_MODE = v.mode;
        ZERO    = v.z;
        NEG     = v.n;
        JUMP    = v.j;
        CALL    = v.c;
        RET     = v.r;
        OFFSET  = v.off;
        #1;
        if (!v.rst) chk({tag, " nextpc"}, NEXTPC, v.nxt);
        @(posedge CLK);
        #1;
        chk({tag, " pc"},    PC,               v.pc);
        chk({tag, " empty"}, {31'd0, RAS_EMPTY}, {31'd0, v.e});
        chk({tag, " full"},  {31'd0, RAS_FULL},  {31'd0, v.f});
        chk({tag, " err"},   {31'd0, RAS_ERR},   {31'd0, v.err});
    endtask

    initial begin
        //            rst st br md z n j c r  off    nxt      pc       e f err
        vq.push_back('{1, 0, 0, 0, 0,0,0,0,0, 8'h00, 32'h00, 32'h00, 1,0,0}); // 0 reset
        vq.push_back('{0, 0, 0, 0, 0,0,0,0,0, 8'h00, 32'h04, 32'h04, 1,0,0});
        vq.push_back('{0, 0, 0, 0, 0,0,0,0,0, 8'h00, 32'h08, 32'h08, 1,0,0});
        vq.push_back('{0, 0, 0, 0, 0,0,0,0,0, 8'h00, 32'h0C, 32'h0C, 1,0,0});
        vq.push_back('{0, 0, 0, 0, 0,0,1,0,0, 8'h04, 32'h20, 32'h20, 1,0,0}); // 4 jump
        vq.push_back('{0, 0, 1, 1, 0,0,0,0,0, 8'hFD, 32'h18, 32'h18, 1,0,0}); // BNE taken
        vq.push_back('{0, 0, 0, 0, 0,0,1,0,0, 8'h01, 32'h20, 32'h20, 1,0,0});
        vq.push_back('{0, 0, 1, 1, 1,0,0,0,0, 8'hFD, 32'h24, 32'h24, 1,0,0}); // BNE not
        vq.push_back('{0, 0, 1, 0, 1,0,0,0,0, 8'h02, 32'h30, 32'h30, 1,0,0}); // BEQ taken
        vq.push_back('{0, 0, 1, 2, 0,0,0,0,0, 8'h05, 32'h34, 32'h34, 1,0,0}); // BLT not
        vq.push_back('{0, 0, 1, 3, 0,0,0,0,0, 8'h01, 32'h3C, 32'h3C, 1,0,0}); // BGE taken
        vq.push_back('{0, 0, 1, 2, 0,1,0,0,0, 8'hFF, 32'h3C, 32'h3C, 1,0,0}); // BLT taken
        vq.push_back('{0, 0, 1, 3, 0,1,0,0,0, 8'h07, 32'h40, 32'h40, 1,0,0}); // BGE not
        vq.push_back('{0, 0, 0, 0, 0,0,0,1,0, 8'h04, 32'h54, 32'h54, 0,0,0}); // 13 call
        vq.push_back('{0, 0, 0, 0, 0,0,0,0,1, 8'h00, 32'h44, 32'h44, 1,0,0}); // ret
        vq.push_back('{0, 1, 0, 0, 0,0,0,1,0, 8'h02, 32'h50, 32'h44, 1,0,0}); // stalled call
        vq.push_back('{0, 1, 0, 0, 0,0,0,1,0, 8'h02, 32'h50, 32'h44, 1,0,0});
        vq.push_back('{0, 0, 0, 0, 0,0,0,1,0, 8'h02, 32'h50, 32'h50, 0,0,0});
        vq.push_back('{0, 0, 0, 0, 0,0,0,0,1, 8'h00, 32'h48, 32'h48, 1,0,0}); // single push
        vq.push_back('{0, 0, 0, 0, 0,0,0,1,0, 8'h00, 32'h4C, 32'h4C, 0,0,0});
        vq.push_back('{0, 0, 0, 0, 0,0,0,1,1, 8'h05, 32'h4C, 32'h4C, 1,0,0}); // 20 call+ret
        vq.push_back('{0, 0, 0, 0, 0,0,0,1,0, 8'h01, 32'h54, 32'h54, 0,0,0}); // push 0x50
        vq.push_back('{0, 0, 0, 0, 0,0,0,1,0, 8'h01, 32'h5C, 32'h5C, 0,0,0}); // push 0x58
        vq.push_back('{0, 0, 0, 0, 0,0,0,1,0, 8'h01, 32'h64, 32'h64, 0,0,0}); // push 0x60
        vq.push_back('{0, 0, 0, 0, 0,0,0,1,0, 8'h01, 32'h6C, 32'h6C, 0,1,0}); // push 0x68
        vq.push_back('{0, 0, 0, 0, 0,0,0,1,0, 8'h01, 32'h74, 32'h74, 0,1,1}); // overflow
        vq.push_back('{0, 0, 0, 0, 0,0,0,0,1, 8'h00, 32'h70, 32'h70, 0,0,1});
        vq.push_back('{0, 0, 0, 0, 0,0,0,0,1, 8'h00, 32'h68, 32'h68, 0,0,1});
        vq.push_back('{0, 0, 0, 0, 0,0,0,0,1, 8'h00, 32'h60, 32'h60, 0,0,1});
        vq.push_back('{0, 0, 0, 0, 0,0,1,0,1, 8'h09, 32'h58, 32'h58, 1,0,1}); // ret beats jump
        vq.push_back('{0, 0, 0, 0, 0,0,0,0,1, 8'h00, 32'h5C, 32'h5C, 1,0,1}); // underflow
        vq.push_back('{0, 0, 0, 0, 0,0,1,0,0, 8'h08, 32'h80, 32'h80, 1,0,1});
        vq.push_back('{1, 1, 0, 0, 0,0,0,1,0, 8'h00, 32'h00, 32'h00, 1,0,0}); // reset wins
        vq.push_back('{0, 0, 0, 0, 0,0,0,0,0, 8'h00, 32'h04, 32'h04, 1,0,0});

        for (int i = 0; i < vq.size(); i++) begin
            step($sformatf("row%0d", i), vq[i]);
        end

        // Address wrap modulo 2^32, then a RET held across a stall.
        step("wrap_rst",  '{1, 0, 0, 0, 0,0,0,0,0, 8'h00, 32'h0, 32'h0, 1,0,0});
        step("wrap_back", '{0, 0, 0, 0, 0,0,1,0,0, 8'hFE, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1,0,0});
        step("wrap_fwd",  '{0, 0, 0, 0, 0,0,0,0,0, 8'h00, 32'h0, 32'h0, 1,0,0});
        step("sret_call", '{0, 0, 0, 0, 0,0,0,1,0, 8'h03, 32'h10, 32'h10, 0,0,0});
        step("sret_st0",  '{0, 1, 0, 0, 0,0,0,0,1, 8'h00, 32'h04, 32'h10, 0,0,0});
        step("sret_st1",  '{0, 1, 0, 0, 0,0,0,0,1, 8'h00, 32'h04, 32'h10, 0,0,0});
        step("sret_go",   '{0, 0, 0, 0, 0,0,0,0,1, 8'h00, 32'h04, 32'h04, 1,0,0});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
